pattern_pwm_mc: RTL



---
 rtl/pattern_pwm_pkg.sv | 13 +
 rtl/pattern_pwm_ch.sv | 143 ++++++++++++++
 rtl/pattern_pwm_mc.sv | 45 ++++
 3 files changed

// File: rtl/pattern_pwm_pkg.sv
// Shared types and helpers for the multi-channel pattern PWM generator.
package pattern_pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_e;

   function automatic int idx_width(input int pat_width);
      return (pat_width > 2) ? $clog2(pat_width) : 1;
   endfunction

endpackage

// File: rtl/pattern_pwm_ch.sv
// Single-channel pattern serialiser: latched config, hold/index/repeat counters.
//
// state | meaning
// IDLE  | output parked at latched idle level, waiting for a start strobe
// RUN   | shifting the latched pattern out, busy high
module pattern_pwm_ch
   import pattern_pwm_pkg::*;
#(
   parameter int PAT_W  = 16,
   parameter int HOLD_W = 8,
   parameter int RPT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_en,
   input  logic              abort,
   input  logic [HOLD_W-1:0] duty_num,
   input  logic [RPT_W-1:0]  rpt_num,
   input  logic [PAT_W-1:0]  pat,
   input  logic              lsb_first,
   input  logic              idle_lvl,
   output logic              pwm_out,
   output logic              busy,
   output logic              valid
);

   localparam int IDX_W = idx_width(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   pwm_state_e        state_q, state_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [HOLD_W-1:0] duty_q, duty_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [RPT_W-1:0]  rpt_q, rpt_d;
   logic              lsb_q, lsb_d;
   logic              idle_q, idle_d;
   logic              pwm_q, pwm_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;

   function automatic logic pat_bit(input logic [PAT_W-1:0] p,
                                    input logic [IDX_W-1:0] i,
                                    input logic             lsb);
      logic [IDX_W-1:0] sel;
      sel = lsb ? i : (IDX_LAST - i);
      return p[sel];
   endfunction

   // Hold and repeat are down-counters loaded from the latched maxima; index counts up
   // because it directly selects the pattern bit.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      rpt_d   = rpt_q;
      lsb_d   = lsb_q;
      idle_d  = idle_q;
      pwm_d   = pwm_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            pwm_d  = idle_q;
            busy_d = 1'b0;
            if (pwm_en && !abort) begin
               state_d = RUN;
               pat_d   = pat;
               duty_d  = duty_num;
               hold_d  = duty_num;
               rpt_d   = rpt_num;
               lsb_d   = lsb_first;
               idle_d  = idle_lvl;
               idx_d   = '0;
               busy_d  = 1'b1;
               pwm_d   = pat_bit(pat, '0, lsb_first);
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               pwm_d   = idle_q;
            end else if (hold_q != '0) begin
               hold_d = hold_q - 1'b1;
            end else begin
               hold_d = duty_q;
               if (idx_q == IDX_LAST) begin
                  if (rpt_q == '0) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     valid_d = 1'b1;
                     pwm_d   = idle_q;
                  end else begin
                     rpt_d = rpt_q - 1'b1;
                     idx_d = '0;
                     pwm_d = pat_bit(pat_q, '0, lsb_q);
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
                  pwm_d = pat_bit(pat_q, idx_d, lsb_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         duty_q  <= '0;
         hold_q  <= '0;
         idx_q   <= '0;
         rpt_q   <= '0;
         lsb_q   <= 1'b0;
         idle_q  <= 1'b0;
         pwm_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         rpt_q   <= rpt_d;
         lsb_q   <= lsb_d;
         idle_q  <= idle_d;
         pwm_q   <= pwm_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign pwm_out = pwm_q;
   assign busy    = busy_q;
   assign valid   = valid_q;

endmodule

// File: rtl/pattern_pwm_mc.sv
// Multi-channel pattern PWM generator: independent channel engines on flattened buses.
module pattern_pwm_mc
   import pattern_pwm_pkg::*;
#(
   parameter int _PAT_WIDTH  = 16,
   parameter int _CH_NUM     = 2,
   parameter int _HOLD_WIDTH = 8,
   parameter int _RPT_WIDTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [_CH_NUM-1:0]              pwm_en,
   input  logic [_CH_NUM-1:0]              abort,
   input  logic [_CH_NUM*_HOLD_WIDTH-1:0]  duty_num,
   input  logic [_CH_NUM*_RPT_WIDTH-1:0]   rpt_num,
   input  logic [_CH_NUM*_PAT_WIDTH-1:0]   PAT,
   input  logic [_CH_NUM-1:0]              lsb_first,
   input  logic [_CH_NUM-1:0]              idle_lvl,
   output logic [_CH_NUM-1:0]              pwm_out,
   output logic [_CH_NUM-1:0]              busy,
   output logic [_CH_NUM-1:0]              valid
);

   for (genvar g = 0; g < _CH_NUM; g++) begin : g_ch
      pattern_pwm_ch #(
         .PAT_W  (_PAT_WIDTH),
         .HOLD_W (_HOLD_WIDTH),
         .RPT_W  (_RPT_WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .pwm_en    (pwm_en[g]),
         .abort     (abort[g]),
         .duty_num  (duty_num[g*_HOLD_WIDTH +: _HOLD_WIDTH]),
         .rpt_num   (rpt_num[g*_RPT_WIDTH +: _RPT_WIDTH]),
         .pat       (PAT[g*_PAT_WIDTH +: _PAT_WIDTH]),
         .lsb_first (lsb_first[g]),
         .idle_lvl  (idle_lvl[g]),
         .pwm_out   (pwm_out[g]),
         .busy      (busy[g]),
         .valid     (valid[g])
      );
   end

endmodule
